// File: rtl/seq_chk_pkg.sv
// Shared definitions for the custom-sequence checker: FSM state encoding,
// the five legal {a,b,c} codes, and the code-to-index / successor lookups.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] CODE_0 = 3'b000;
  localparam logic [2:0] CODE_1 = 3'b010;
  localparam logic [2:0] CODE_2 = 3'b011;
  localparam logic [2:0] CODE_3 = 3'b101;
  localparam logic [2:0] CODE_4 = 3'b111;

  localparam logic [2:0] IDX_FIRST = 3'd0;
  localparam logic [2:0] IDX_LAST  = 3'd4;

  // Returns {legal, index}; illegal codes report index 0.
  function automatic logic [3:0] code_lookup(input logic [2:0] code);
    case (code)
      CODE_0:  return {1'b1, 3'd0};
      CODE_1:  return {1'b1, 3'd1};
      CODE_2:  return {1'b1, 3'd2};
      CODE_3:  return {1'b1, 3'd3};
      CODE_4:  return {1'b1, 3'd4};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] i);
    return (i == IDX_LAST) ? IDX_FIRST : i + 3'd1;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational decoder from a received {a,b,c} code to {legal, index}.
module seq_decode
  import seq_chk_pkg::*;
(
  input  logic [2:0] code,
  output logic       legal,
  output logic [2:0] index
);

  assign {legal, index} = code_lookup(code);

endmodule

// File: rtl/seq_checker.sv
// Receive-side lock/decode checker for the 3-bit custom-sequence counter.
// Optional error counter: define SEQ_CHK_ERR_CNT_EN to build err_cnt.
module seq_checker
  import seq_chk_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int LOSS_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [2:0]       code,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [2:0] LOCK_RUN  = 3'(LOCK_N);
  localparam logic [2:0] LOSS_MISS = 3'(LOSS_N);

  state_t     state, state_nxt;
  logic [2:0] exp, exp_nxt;
  logic [2:0] run, run_nxt;
  logic [2:0] miss, miss_nxt;
  logic [2:0] idx_nxt;
  logic       idx_valid_nxt, locked_nxt, err_nxt, wrap_nxt;
  logic       legal;
  logic [2:0] index;

  seq_decode u_decode (
    .code  (code),
    .legal (legal),
    .index (index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      exp       <= '0;
      run       <= '0;
      miss      <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp       <= exp_nxt;
      run       <= run_nxt;
      miss      <= miss_nxt;
      idx       <= idx_nxt;
      idx_valid <= idx_valid_nxt;
      locked    <= locked_nxt;
      err       <= err_nxt;
      wrap      <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    exp_nxt       = exp;
    run_nxt       = run;
    miss_nxt      = miss;
    idx_nxt       = idx;
    idx_valid_nxt = 1'b0;
    err_nxt       = 1'b0;
    wrap_nxt      = 1'b0;

    if (code_valid) begin
      unique case (state)
        HUNT: begin
          if (legal) begin
            exp_nxt = succ(index);
            run_nxt = 3'd1;
            if (LOCK_RUN == 3'd1) begin
              state_nxt     = LOCKED;
              idx_nxt       = index;
              idx_valid_nxt = 1'b1;
              miss_nxt      = '0;
            end else begin
              state_nxt = ACQ;
            end
          end
        end

        ACQ: begin
          if (!legal) begin
            state_nxt = HUNT;
            run_nxt   = '0;
          end else if (index == exp) begin
            run_nxt = run + 3'd1;
            exp_nxt = succ(exp);
            if (run + 3'd1 == LOCK_RUN) begin
              state_nxt     = LOCKED;
              idx_nxt       = index;
              idx_valid_nxt = 1'b1;
              miss_nxt      = '0;
            end
          end else begin
            run_nxt = 3'd1;
            exp_nxt = succ(index);
          end
        end

        LOCKED: begin
          // Mismatches still advance exp so a single corrupt code is bridged.
          exp_nxt = succ(exp);
          if (legal && index == exp) begin
            idx_nxt       = index;
            idx_valid_nxt = 1'b1;
            miss_nxt      = '0;
            wrap_nxt      = (index == IDX_FIRST) && (idx == IDX_LAST);
          end else begin
            err_nxt  = 1'b1;
            miss_nxt = miss + 3'd1;
            if (miss + 3'd1 == LOSS_MISS) begin
              state_nxt = HUNT;
              run_nxt   = '0;
            end
          end
        end

        default: state_nxt = HUNT;
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);
  end

`ifdef SEQ_CHK_ERR_CNT_EN
  localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  logic [ERR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (err_nxt && cnt != '1)
      cnt <= cnt + CNT_ONE;
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_checker.sv
// Table-driven bench for seq_checker (LOCK_N=3, LOSS_N=2, ERR_W=2) with a
// scoreboard queue of expected outputs; honours SEQ_CHK_ERR_CNT_EN.
module tb_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'b000;
  logic [2:0] idx;
  logic       idx_valid, locked, err, wrap;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] code;
    logic [2:0] idx;
    logic       iv;
    logic       lk;
    logic       er;
    logic       wr;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  seq_checker #(.LOCK_N(3), .LOSS_N(2), .ERR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code       (code),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .locked     (locked),
    .err        (err),
    .wrap       (wrap),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input int r, input int v, input int c, input int ix,
                     input int iv, input int lk, input int er, input int wr,
                     input int cnt);
    vec_t t;
    t.rst  = 1'(r);
    t.vld  = 1'(v);
    t.code = 3'(c);
    t.idx  = 3'(ix);
    t.iv   = 1'(iv);
    t.lk   = 1'(lk);
    t.er   = 1'(er);
    t.wr   = 1'(wr);
    t.cnt  = 2'(cnt);
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int n, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, required %0d", name, n, act, req);
    end
  endtask

  task automatic step(input vec_t v, input int n);
    vec_t e;
    logic [1:0] cnt_req;
    sb.push_back(v);
    rst        = v.rst;
    code_valid = v.vld;
    code       = v.code;
    @(posedge clk);
    #1;
    e = sb.pop_front();
`ifdef SEQ_CHK_ERR_CNT_EN
    cnt_req = e.cnt;
`else
    cnt_req = 2'd0;
`endif
    chk("idx",       n, 8'(idx),       8'(e.idx));
    chk("idx_valid", n, 8'(idx_valid), 8'(e.iv));
    chk("locked",    n, 8'(locked),    8'(e.lk));
    chk("err",       n, 8'(err),       8'(e.er));
    chk("wrap",      n, 8'(wrap),      8'(e.wr));
    chk("err_cnt",   n, 8'(err_cnt),   8'(cnt_req));
  endtask

  task automatic drive(input int r, input int v, input int c, input int ix,
                       input int iv, input int lk, input int er, input int wr,
                       input int cnt, input int n);
    vec_t t;
    t.rst  = 1'(r);
    t.vld  = 1'(v);
    t.code = 3'(c);
    t.idx  = 3'(ix);
    t.iv   = 1'(iv);
    t.lk   = 1'(lk);
    t.er   = 1'(er);
    t.wr   = 1'(wr);
    t.cnt  = 2'(cnt);
    step(t, n);
  endtask

  initial begin
    //  rst vld code    idx iv lk er wr cnt
    add(1, 0, 'b000,  0, 0, 0, 0, 0, 0);
    // Lock on 000, 010, 011
    add(0, 1, 'b000,  0, 0, 0, 0, 0, 0);
    add(0, 1, 'b010,  0, 0, 0, 0, 0, 0);
    add(0, 1, 'b011,  2, 1, 1, 0, 0, 0);
    // Wrap through 101, 111, 000
    add(0, 1, 'b101,  3, 1, 1, 0, 0, 0);
    add(0, 1, 'b111,  4, 1, 1, 0, 0, 0);
    add(0, 1, 'b000,  0, 1, 1, 0, 1, 0);
    add(0, 0, 'b110,  0, 0, 1, 0, 0, 0);
    add(0, 1, 'b010,  1, 1, 1, 0, 0, 0);
    add(0, 1, 'b011,  2, 1, 1, 0, 0, 0);
    // Flywheel: illegal 110 while expecting 3, then 111
    add(0, 1, 'b110,  2, 0, 1, 1, 0, 1);
    add(0, 1, 'b111,  4, 1, 1, 0, 0, 1);
    add(0, 1, 'b000,  0, 1, 1, 0, 1, 1);
    add(0, 1, 'b010,  1, 1, 1, 0, 0, 1);
    add(0, 1, 'b011,  2, 1, 1, 0, 0, 1);
    // Loss of lock: 000, 000 while expecting 3, then re-lock
    add(0, 1, 'b000,  2, 0, 1, 1, 0, 2);
    add(0, 1, 'b000,  2, 0, 0, 1, 0, 3);
    add(0, 1, 'b010,  2, 0, 0, 0, 0, 3);
    add(0, 1, 'b011,  2, 0, 0, 0, 0, 3);
    add(0, 1, 'b101,  3, 1, 1, 0, 0, 3);
    // Saturation at 3 across further misses
    add(0, 1, 'b001,  3, 0, 1, 1, 0, 3);
    add(0, 1, 'b000,  0, 1, 1, 0, 0, 3);
    add(0, 1, 'b011,  0, 0, 1, 1, 0, 3);
    add(0, 1, 'b100,  0, 0, 0, 1, 0, 3);
    // HUNT illegal, ACQ restart, ACQ illegal back to HUNT, lock on 0
    add(0, 1, 'b110,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b111,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b010,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b011,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b100,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b101,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b111,  0, 0, 0, 0, 0, 3);
    add(0, 1, 'b000,  0, 1, 1, 0, 0, 3);
    // Reset with code_valid, then lock with gaps carrying garbage
    add(1, 1, 'b010,  0, 0, 0, 0, 0, 0);
    add(0, 0, 'b111,  0, 0, 0, 0, 0, 0);
    add(0, 1, 'b000,  0, 0, 0, 0, 0, 0);
    add(0, 0, 'b110,  0, 0, 0, 0, 0, 0);
    add(0, 0, 'b011,  0, 0, 0, 0, 0, 0);
    add(0, 1, 'b010,  0, 0, 0, 0, 0, 0);
    add(0, 0, 'b101,  0, 0, 0, 0, 0, 0);
    add(0, 1, 'b011,  2, 1, 1, 0, 0, 0);
    add(0, 0, 'b000,  2, 0, 1, 0, 0, 0);
    add(0, 0, 'b001,  2, 0, 1, 0, 0, 0);
    add(0, 1, 'b101,  3, 1, 1, 0, 0, 0);
    add(0, 1, 'b111,  4, 1, 1, 0, 0, 0);
    // Reset mid-stream forces re-acquisition
    add(1, 1, 'b000,  0, 0, 0, 0, 0, 0);
    add(0, 1, 'b011,  0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) step(vecs[i], i);

    // Long idle gap in ACQ with random codes, then finish lock and wrap
    for (int k = 0; k < 16; k++)
      drive(0, 0, int'($urandom_range(7)), 0, 0, 0, 0, 0, 0, 100 + k);
    drive(0, 1, 'b101, 0, 0, 0, 0, 0, 0, 200);
    drive(0, 1, 'b111, 4, 1, 1, 0, 0, 0, 201);
    drive(0, 1, 'b000, 0, 1, 1, 0, 1, 0, 202);
    drive(0, 1, 'b000, 0, 0, 1, 1, 0, 1, 203);
    drive(0, 1, 'b011, 2, 1, 1, 0, 0, 1, 204);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
